// File: rtl/adex_spike_monitor_if.sv
// adex_spike_monitor_if: spike input, run control and byte readback port of the spike monitor
interface adex_spike_monitor_if;
  logic       spike_in;
  logic       enable;
  logic       clear;
  logic [1:0] rd_sel;
  logic [7:0] rd_data;
  logic       window_done;
  modport master (output spike_in, enable, clear, rd_sel, input rd_data, window_done);
  modport slave  (input spike_in, enable, clear, rd_sel, output rd_data, window_done);
endinterface

// File: rtl/adex_spike_monitor.sv
// adex_spike_monitor: windowed spike rate, inter-spike interval and optional burst flag (SPIKE_MON_BURST_EN) with byte readback
module adex_spike_monitor #(
  parameter int WINDOW_LEN = 1000
`ifdef SPIKE_MON_BURST_EN
  , parameter int BURST_ISI = 32
`endif
) (
  input logic clk,
  input logic rst_n,
  adex_spike_monitor_if.slave bus
);
  localparam int WW = $clog2(WINDOW_LEN + 1);
  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;
  state_t state, state_n;
  logic spike_q, spk_edge, active, win_close, rec_isi;
  logic [WW-1:0] win_cnt;
  logic [7:0] cnt, cnt_inc, rate;
  logic ovf, ovf_n, rate_ovf;
  logic [15:0] isi_cnt, last_isi;
  logic isi_valid, isi_sat, burst_flag;
  // next state and per-cycle qualifiers; clear overrides everything, disabling drops to IDLE
  always_comb begin
    spk_edge = bus.spike_in & ~spike_q;
    active = !bus.clear && bus.enable && state != IDLE;
    state_n = bus.clear ? (bus.enable ? ARMED : IDLE) :
              !bus.enable ? IDLE :
              state == IDLE ? ARMED :
              spk_edge ? RUN : state;
    win_close = active && win_cnt == WW'(WINDOW_LEN - 1);
    rec_isi = active && spk_edge && state == RUN;
    cnt_inc = (spk_edge && cnt != 8'hFF) ? cnt + 8'd1 : cnt;
    ovf_n = ovf | (spk_edge & (cnt == 8'hFF));
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // previous spike level for rising-edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) spike_q <= 1'b0;
    else spike_q <= bus.spike_in;
  // window/rate and ISI measurement; the edge in a closing cycle still belongs to that window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      isi_cnt <= '0;
      rate <= '0;
      rate_ovf <= 1'b0;
      last_isi <= '0;
      isi_valid <= 1'b0;
      isi_sat <= 1'b0;
      bus.window_done <= 1'b0;
    end else if (!active) begin
      win_cnt <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      isi_cnt <= '0;
      bus.window_done <= 1'b0;
      if (bus.clear) begin
        rate <= '0;
        rate_ovf <= 1'b0;
        last_isi <= '0;
        isi_valid <= 1'b0;
        isi_sat <= 1'b0;
      end
    end else begin
      bus.window_done <= win_close;
      win_cnt <= win_close ? '0 : win_cnt + 1'b1;
      cnt <= win_close ? '0 : cnt_inc;
      ovf <= win_close ? 1'b0 : ovf_n;
      if (win_close) begin
        rate <= cnt_inc;
        rate_ovf <= ovf_n;
      end
      if (spk_edge) isi_cnt <= 16'd1;
      else if (state == RUN && isi_cnt != 16'hFFFF) isi_cnt <= isi_cnt + 16'd1;
      if (rec_isi) begin
        last_isi <= isi_cnt;
        isi_valid <= 1'b1;
        isi_sat <= isi_cnt == 16'hFFFF;
      end
    end
  end
`ifdef SPIKE_MON_BURST_EN
  logic [1:0] burst_cnt;
  // run of consecutive short ISIs; the third one raises the flag, a long one drops it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= '0;
      burst_flag <= 1'b0;
    end else if (!active) begin
      burst_cnt <= '0;
      if (bus.clear) burst_flag <= 1'b0;
    end else if (rec_isi) begin
      if (isi_cnt < 16'(BURST_ISI)) begin
        burst_cnt <= burst_cnt == 2'd3 ? 2'd3 : burst_cnt + 2'd1;
        if (burst_cnt >= 2'd2) burst_flag <= 1'b1;
      end else begin
        burst_cnt <= '0;
        burst_flag <= 1'b0;
      end
    end
  end
`else
  assign burst_flag = 1'b0;
`endif
  // registered byte readback
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bus.rd_data <= '0;
    else bus.rd_data <= bus.rd_sel == 2'd0 ? rate :
                        bus.rd_sel == 2'd1 ? last_isi[15:8] :
                        bus.rd_sel == 2'd2 ? last_isi[7:0] :
                        {isi_valid, rate_ovf, burst_flag, isi_sat, 4'b0};
endmodule

// File: tb/tb_adex_spike_monitor.sv
// tb_adex_spike_monitor: scoreboard bench with a time-based reference model of rate, ISI and burst
module tb_adex_spike_monitor;
  localparam int WL = 1000;
  localparam int BISI = 32;
`ifdef SPIKE_MON_BURST_EN
  localparam logic [7:0] STAT_BURST = 8'h20;
`else
  localparam logic [7:0] STAT_BURST = 8'h00;
`endif
  typedef struct {logic wd; logic [7:0] rd;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  exp_t mon_e;
  int t, m_mode, m_wcyc, m_cnt, m_last_t, m_bchain;
  logic m_prev, m_ovf, m_valid, m_sat, m_bflag;
  logic [7:0] m_rate;
  logic [15:0] m_isi;
  adex_spike_monitor_if bus();
  adex_spike_monitor #(.WINDOW_LEN(WL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask
  task automatic run_reset();
    m_cnt = 0;
    m_wcyc = 0;
    m_bchain = 0;
  endtask
  task automatic model_reset();
    run_reset();
    t = 0;
    m_mode = 0;
    m_last_t = 0;
    m_prev = 0;
    m_rate = 0;
    m_ovf = 0;
    m_isi = 0;
    m_valid = 0;
    m_sat = 0;
    m_bflag = 0;
  endtask
  // one clock of reference behaviour: readback reflects values before this edge
  task automatic model_step(input logic s, input logic en, input logic clr, input logic [1:0] sel);
    exp_t e;
    logic ed;
    int isi;
    e.rd = sel == 2'd0 ? m_rate : sel == 2'd1 ? m_isi[15:8] : sel == 2'd2 ? m_isi[7:0] :
           {m_valid, m_ovf, m_bflag, m_sat, 4'b0};
    e.wd = 1'b0;
    ed = s && !m_prev;
    m_prev = s;
    if (clr) begin
      m_rate = 0; m_ovf = 0; m_isi = 0; m_valid = 0; m_sat = 0; m_bflag = 0;
      run_reset();
      m_mode = en ? 1 : 0;
    end else if (m_mode == 0) begin
      m_mode = en ? 1 : 0;
    end else if (!en) begin
      run_reset();
      m_mode = 0;
    end else begin
      if (ed) begin
        m_cnt++;
        if (m_mode == 2) begin
          isi = t - m_last_t;
          if (isi > 65535) isi = 65535;
          m_isi = 16'(isi);
          m_valid = 1;
          m_sat = isi == 65535;
          if (isi < BISI) begin
            m_bchain++;
`ifdef SPIKE_MON_BURST_EN
            if (m_bchain >= 3) m_bflag = 1;
`endif
          end else begin
            m_bchain = 0;
            m_bflag = 0;
          end
        end
        m_last_t = t;
        m_mode = 2;
      end
      m_wcyc++;
      if (m_wcyc == WL) begin
        m_rate = m_cnt > 255 ? 8'hFF : 8'(m_cnt);
        m_ovf = m_cnt > 255;
        m_cnt = 0;
        m_wcyc = 0;
        e.wd = 1'b1;
      end
    end
    q.push_back(e);
    t++;
  endtask
  task automatic step(input logic s, input logic en, input logic clr, input int sel);
    bus.spike_in = s;
    bus.enable = en;
    bus.clear = clr;
    bus.rd_sel = sel < 0 ? 2'($urandom_range(0, 3)) : 2'(sel);
    @(posedge clk);
    model_step(s, en, clr, bus.rd_sel);
    #1;
  endtask
  // monitor: every cycle out of reset the DUT presents window_done and rd_data
  always @(negedge clk)
    if (rst_n && q.size() > 0) begin
      mon_e = q.pop_front();
      chk("window_done", 16'(bus.window_done), 16'(mon_e.wd));
      chk("rd_data", 16'(bus.rd_data), 16'(mon_e.rd));
    end
  initial begin
    bus.spike_in = 0; bus.enable = 0; bus.clear = 0; bus.rd_sel = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_data", 16'(bus.rd_data), 16'h0);
    chk("reset_window_done", 16'(bus.window_done), 16'h0);
    rst_n = 1;
    step(0, 1, 0, -1);
    for (int i = 0; i < 1000; i++) step(i % 100 == 0, 1, 0, -1);
    step(0, 1, 0, 0); chk("rate_10", 16'(bus.rd_data), 16'd10);
    step(0, 1, 0, 1); chk("isi_hi_100", 16'(bus.rd_data), 16'h00);
    step(0, 1, 0, 2); chk("isi_lo_100", 16'(bus.rd_data), 16'h64);
    step(0, 1, 0, 3); chk("status_valid", 16'(bus.rd_data), 16'h80);
    for (int i = 0; i < 60; i++) step(i % 50 < 5, 1, 0, -1);
    step(0, 1, 0, 1); chk("held_isi_hi", 16'(bus.rd_data), 16'h00);
    step(0, 1, 0, 2); chk("held_isi_lo_50", 16'(bus.rd_data), 16'h32);
    step(0, 1, 1, -1);
    for (int i = 0; i < 1000; i++) step(i % 2 == 0, 1, 0, -1);
    step(0, 1, 0, 0); chk("rate_sat_255", 16'(bus.rd_data), 16'hFF);
    step(0, 1, 0, 3); chk("status_ovf", 16'(bus.rd_data), 16'(8'hC0 | STAT_BURST));
    for (int i = 0; i < 998; i++) step(i % 100 == 0, 1, 0, -1);
    step(0, 1, 0, 0); chk("rate_back_10", 16'(bus.rd_data), 16'd10);
    step(0, 1, 0, 3); chk("status_ovf_gone", 16'(bus.rd_data), 16'h80);
    step(1, 1, 0, -1);
    for (int i = 0; i < 70000; i++) step(0, 1, 0, -1);
    step(1, 1, 0, -1);
    step(0, 1, 0, 1); chk("isi_sat_hi", 16'(bus.rd_data), 16'hFF);
    step(0, 1, 0, 2); chk("isi_sat_lo", 16'(bus.rd_data), 16'hFF);
    step(0, 1, 0, 3); chk("status_sat", 16'(bus.rd_data), 16'h90);
    for (int i = 0; i < 100; i++) step(0, 1, 0, -1);
    for (int i = 0; i < 82; i++) begin
      step((i <= 30 && i % 10 == 0) || i == 80, 1, 0, (i == 31 || i == 81) ? 3 : -1);
      if (i == 31) chk("burst_set", 16'(bus.rd_data), 16'(8'h80 | STAT_BURST));
      if (i == 81) chk("burst_clear", 16'(bus.rd_data), 16'h80);
    end
    for (int i = 0; i < 300; i++) step(i % 100 == 0, 1, 0, -1);
    step(0, 1, 0, 2);
    #2 rst_n = 0;
    #1;
    chk("async_rst_rd_data", 16'(bus.rd_data), 16'h0);
    chk("async_rst_window_done", 16'(bus.window_done), 16'h0);
    q.delete();
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    step(0, 1, 0, -1);
    for (int i = 0; i < 250; i++) step(i % 100 == 0, 1, 0, -1);
    step(0, 1, 1, -1);
    for (int s = 0; s < 4; s++) begin
      step(0, 1, 0, s);
      chk("clear_readback", 16'(bus.rd_data), 16'h0);
    end
    step(1, 1, 0, -1);
    step(0, 1, 0, 3); chk("clear_no_isi_status", 16'(bus.rd_data), 16'h0);
    step(0, 1, 0, 2); chk("clear_no_isi_lo", 16'(bus.rd_data), 16'h0);
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 9) < 3, $urandom_range(0, 299) != 0, $urandom_range(0, 599) == 0, -1);
    repeat (2) @(negedge clk);
    chk("queue_drained", 16'(q.size()), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
